// File: rtl/alarm_clock_set_ctrl.sv
// Mode/adjust controller for the alarm clock counter bank: RUN / ADJ / RING sequencing and button-to-enable pulses.
// Optional build macro AUTO_REPEAT_EN adds auto-repeat for a held up/down button while adjusting.
module alarm_clock_set_ctrl #(
    parameter int RING_TICKS    = 60,
    parameter int TIMEOUT_TICKS = 30,
    parameter int REPEAT_DLY    = 50_000_000,
    parameter int REPEAT_RATE   = 10_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       btn_c,
    input  logic       btn_l,
    input  logic       btn_r,
    input  logic       btn_u,
    input  logic       btn_d,
    input  logic       alarm_on,
    input  logic       alarm_match,
    output logic       run_en,
    output logic [3:0] adj_en,
    output logic       adj_dir,
    output logic [1:0] sel,
    output logic [1:0] mode,
    output logic       blink,
    output logic       buzz
);

    typedef enum logic [1:0] {
        RUN  = 2'b00,
        ADJ  = 2'b01,
        RING = 2'b10
    } mode_t;

    localparam int RING_W = $clog2(RING_TICKS + 1);
    localparam int IDLE_W = $clog2(TIMEOUT_TICKS + 1);

    mode_t             state;
    logic [4:0]        btn, prev, edges;
    logic              armed;
    logic [RING_W-1:0] ring_cnt;
    logic [IDLE_W-1:0] idle_cnt;
    logic              rep_fire, rep_dn;

    function automatic logic [RING_W-1:0] ring_inc(input logic [RING_W-1:0] v);
        return (v == RING_W'(RING_TICKS)) ? v : v + 1'b1;
    endfunction

    function automatic logic [IDLE_W-1:0] idle_inc(input logic [IDLE_W-1:0] v);
        return (v == IDLE_W'(TIMEOUT_TICKS)) ? v : v + 1'b1;
    endfunction

    // bit order {c, l, r, u, d}
    assign btn    = {btn_c, btn_l, btn_r, btn_u, btn_d};
    assign edges  = btn & ~prev;
    assign run_en = tick_1hz && (state != ADJ);
    assign mode   = state;

`ifdef AUTO_REPEAT_EN
    localparam int HOLD_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

    logic              hold_act, hold_dn, rep_phase, hold_ok, rep_due;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;

    // hold_cnt counts clocks since the press (first phase) or since the last repeat
    assign hold_nxt = hold_cnt + 1'b1;
    assign hold_ok  = (state == ADJ) && !edges[4] && (btn_u ^ btn_d);
    assign rep_due  = rep_phase ? (hold_nxt >= HOLD_W'(REPEAT_RATE))
                                : (hold_nxt >= HOLD_W'(REPEAT_DLY));
    assign rep_fire = hold_ok && hold_act && (btn_d == hold_dn) &&
                      !(edges[1] | edges[0]) && rep_due;
    assign rep_dn   = hold_dn;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_act  <= 1'b0;
            hold_dn   <= 1'b0;
            rep_phase <= 1'b0;
            hold_cnt  <= '0;
        end else if (hold_ok && (edges[1] | edges[0])) begin
            hold_act  <= 1'b1;
            hold_dn   <= btn_d;
            rep_phase <= 1'b0;
            hold_cnt  <= HOLD_W'(1);
        end else if (hold_ok && hold_act && (btn_d == hold_dn)) begin
            if (rep_fire) begin
                hold_cnt  <= '0;
                rep_phase <= 1'b1;
            end else begin
                hold_cnt  <= hold_nxt;
            end
        end else begin
            hold_act  <= 1'b0;
            rep_phase <= 1'b0;
            hold_cnt  <= '0;
        end
    end
`else
    // repeat parameters are inert in this build; the expression is constant false
    assign rep_fire = (REPEAT_DLY < 0) && (REPEAT_RATE < 0);
    assign rep_dn   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            sel      <= 2'd0;
            adj_en   <= 4'd0;
            adj_dir  <= 1'b0;
            blink    <= 1'b0;
            buzz     <= 1'b0;
            armed    <= 1'b1;
            ring_cnt <= '0;
            idle_cnt <= '0;
            prev     <= 5'd0;
        end else begin
            prev   <= btn;
            adj_en <= 4'd0;
            if (!alarm_match)
                armed <= 1'b1;
            case (state)
                RUN: begin
                    if (alarm_on && alarm_match && armed) begin
                        state    <= RING;
                        buzz     <= 1'b1;
                        armed    <= 1'b0;
                        ring_cnt <= '0;
                    end else if (edges[4]) begin
                        state    <= ADJ;
                        sel      <= 2'd0;
                        idle_cnt <= '0;
                    end
                end
                RING: begin
                    if ((|edges) || !alarm_on ||
                        (tick_1hz && (ring_inc(ring_cnt) == RING_W'(RING_TICKS)))) begin
                        state <= RUN;
                        buzz  <= 1'b0;
                    end else if (tick_1hz) begin
                        ring_cnt <= ring_inc(ring_cnt);
                    end
                end
                ADJ: begin
                    if (edges[4]) begin
                        state <= RUN;
                        sel   <= 2'd0;
                        blink <= 1'b0;
                    end else begin
                        if (edges[2] && !edges[3])
                            sel <= sel + 2'd1;
                        else if (edges[3] && !edges[2])
                            sel <= sel - 2'd1;
                        // pulse targets the field selected before any l/r in the same clock
                        if (edges[1] ^ edges[0]) begin
                            adj_en  <= 4'b0001 << sel;
                            adj_dir <= edges[0];
                        end else if (rep_fire) begin
                            adj_en  <= 4'b0001 << sel;
                            adj_dir <= rep_dn;
                        end
                        if ((|edges[3:0]) || rep_fire) begin
                            idle_cnt <= '0;
                        end else if (tick_1hz) begin
                            if (idle_inc(idle_cnt) == IDLE_W'(TIMEOUT_TICKS)) begin
                                state <= RUN;
                                sel   <= 2'd0;
                                blink <= 1'b0;
                            end else begin
                                idle_cnt <= idle_inc(idle_cnt);
                                blink    <= ~blink;
                            end
                        end
                    end
                end
                default: begin
                    state <= RUN;
                    buzz  <= 1'b0;
                    blink <= 1'b0;
                end
            endcase
        end
    end

endmodule
